// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer and its ALU core.
// State and opcode encodings match the board's LED/switch legend.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    WAIT_OP = 2'b10,
    SHOW    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_SUB = 2'b00,
    OP_ADD = 2'b01,
    OP_OR  = 2'b10,
    OP_AND = 2'b11
  } opcode_t;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_P = 0;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Board-side bundle of the operand sequencer: switch bus, enter button and the
// registered values driven to the display/LED logic.
interface alu_operand_sequencer_if #(
  parameter int M = 8
);
  logic [M-1:0] data_in;
  logic         enter;
  logic [1:0]   state_o;
  logic [M-1:0] a_q;
  logic [M-1:0] b_q;
  logic [1:0]   op_q;
  logic [M-1:0] result_q;
  logic [4:0]   flags_q;
  logic         result_valid;
  logic [M-1:0] shown_value;

  modport master (
    output data_in, enter,
    input  state_o, a_q, b_q, op_q, result_q, flags_q, result_valid, shown_value
  );

  modport slave (
    input  data_in, enter,
    output state_o, a_q, b_q, op_q, result_q, flags_q, result_valid, shown_value
  );
endinterface

// File: rtl/alu_core.sv
// Combinational M-bit ALU: SUB/ADD/OR/AND with {N,Z,C,V,P} flags.
// Arithmetic runs on M+1 bits so the top bit is carry (ADD) or borrow (SUB).
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int M = 8
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  opcode_t      opcode,
  output logic [M-1:0] result,
  output logic [4:0]   flags
);

  logic [M:0] ext;
  logic       v;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ext = '0;
    v   = 1'b0;
    case (opcode)
      OP_SUB: begin
        ext = {1'b0, a} - {1'b0, b};
        v   = (ext[M-1] & ~a[M-1] & b[M-1]) | (~ext[M-1] & a[M-1] & ~b[M-1]);
      end
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        v   = (ext[M-1] & ~a[M-1] & ~b[M-1]) | (~ext[M-1] & a[M-1] & b[M-1]);
      end
      OP_OR:   ext = {1'b0, a | b};
      OP_AND:  ext = {1'b0, a & b};
      default: ext = '0;
    endcase
  end

  assign result         = ext[M-1:0];
  assign flags[FLAG_N]  = ext[M-1];
  assign flags[FLAG_Z]  = (ext[M-1:0] == '0);
  // Logic ops leave ext[M] at zero, so C drops out naturally for OR/AND.
  assign flags[FLAG_C]  = ext[M];
  assign flags[FLAG_V]  = v;
  assign flags[FLAG_P]  = ^ext[M-1:0];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode from the switch bus on successive enter presses and
// registers the ALU result; in SHOW the opcode follows the switches live.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int M = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  alu_operand_sequencer_if.slave bus
);

  localparam logic [1:0] ST_WAIT_A  = WAIT_A;
  localparam logic [1:0] ST_WAIT_B  = WAIT_B;
  localparam logic [1:0] ST_WAIT_OP = WAIT_OP;
  localparam logic [1:0] ST_SHOW    = SHOW;

  logic [1:0]   state;
  logic         enter_q;
  logic         enter_pe;
  logic [M-1:0] a_q;
  logic [M-1:0] b_q;
  logic [1:0]   op_q;
  logic [M-1:0] result_q;
  logic [4:0]   flags_q;
  logic         result_valid;
  logic [M-1:0] alu_result;
  logic [4:0]   alu_flags;

  assign enter_pe = bus.enter & ~enter_q;

  alu_core #(.M(M)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .opcode (opcode_t'(op_q)),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_WAIT_A;
      enter_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 2'b00;
      result_q     <= '0;
      flags_q      <= 5'b00000;
      result_valid <= 1'b0;
    end else begin
      // NOTE: state is updated with <= so every branch sees the pre-edge values.
      enter_q <= bus.enter;
      case (state)
        ST_WAIT_A: begin
          result_valid <= 1'b0;
          if (enter_pe) begin
            a_q   <= bus.data_in;
            state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          result_valid <= 1'b0;
          if (enter_pe) begin
            b_q   <= bus.data_in;
            state <= ST_WAIT_OP;
          end
        end
        ST_WAIT_OP: begin
          result_valid <= 1'b0;
          if (enter_pe) begin
            op_q  <= bus.data_in[1:0];
            state <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (enter_pe) begin
            // Leaving SHOW freezes everything on display; an opcode change on
            // this same edge is ignored.
            state        <= ST_WAIT_A;
            result_valid <= 1'b0;
          end else begin
            op_q         <= bus.data_in[1:0];
            result_q     <= alu_result;
            flags_q      <= alu_flags;
            // The result just captured used op_q; it is only current if the
            // switches have not moved away from it.
            result_valid <= (op_q == bus.data_in[1:0]);
          end
        end
        default: state <= ST_WAIT_A;
      endcase
    end
  end

  assign bus.state_o      = state;
  assign bus.a_q          = a_q;
  assign bus.b_q          = b_q;
  assign bus.op_q         = op_q;
  assign bus.result_q     = result_q;
  assign bus.flags_q      = flags_q;
  assign bus.result_valid = result_valid;
  assign bus.shown_value  = (state == ST_SHOW) ? result_q : bus.data_in;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: expected results are queued when an
// operation is entered and popped when result_valid reports them.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

  localparam int M = 8;

  typedef struct {
    logic [M-1:0] r;
    logic [4:0]   f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_operand_sequencer_if #(.M(M)) bus ();

  alu_operand_sequencer #(.M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Independent reference: C and V come from integer range checks.
  function automatic exp_t model(logic [M-1:0] a, logic [M-1:0] b, logic [1:0] op);
    exp_t e;
    int   sa, sb_i, s;
    logic c, v;
    sa   = int'($signed(a));
    sb_i = int'($signed(b));
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      2'b00: begin
        e.r = a - b;
        c   = (a < b);
        s   = sa - sb_i;
        v   = (s > (2 ** (M - 1)) - 1) || (s < -(2 ** (M - 1)));
      end
      2'b01: begin
        e.r = a + b;
        c   = (int'(a) + int'(b)) >= (2 ** M);
        s   = sa + sb_i;
        v   = (s > (2 ** (M - 1)) - 1) || (s < -(2 ** (M - 1)));
      end
      2'b10:   e.r = a | b;
      default: e.r = a & b;
    endcase
    e.f = {e.r[M-1], (e.r == 0), c, v, ^e.r};
    return e;
  endfunction

  task automatic do_enter(input logic [M-1:0] v);
    @(negedge clk);
    bus.data_in = v;
    bus.enter   = 1'b1;
    @(negedge clk);
    bus.enter   = 1'b0;
  endtask

  task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [1:0] op,
                        input logic [M-1:0] er, input logic [4:0] ef);
    exp_t e;
    do_enter(a);
    do_enter(b);
    do_enter(M'(op));
    e.r = er;
    e.f = ef;
    sb.push_back(e);
  endtask

  task automatic exit_show();
    @(negedge clk);
    bus.enter = 1'b1;
    @(negedge clk);
    bus.enter = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.result_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.enter   = 1'b0;
    bus.data_in = '0;
    #3;
    total++;
    if ({bus.state_o, bus.a_q, bus.b_q, bus.op_q, bus.result_q, bus.flags_q, bus.result_valid} !== '0)
      $display("FAIL reset_state: got st=%b a=%h b=%h op=%b r=%h f=%b v=%b, want all zero",
               bus.state_o, bus.a_q, bus.b_q, bus.op_q, bus.result_q, bus.flags_q, bus.result_valid);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Shared body for the directed single-operation scenarios.
  task automatic test_single(input string name, input logic [M-1:0] a, input logic [M-1:0] b,
                             input logic [1:0] op, input logic [M-1:0] er, input logic [4:0] ef);
    bit   ok;
    exp_t e;
    run_op(a, b, op, er, ef);
    total++;
    if (bus.state_o !== 2'b11) $display("FAIL %s_state: got %b want 11", name, bus.state_o);
    else passed++;
    wait_valid(ok);
    e = sb.pop_front();
    total++;
    if (!ok) $display("FAIL %s_valid: result_valid never rose within 8 cycles", name);
    else if (bus.result_q !== e.r || bus.flags_q !== e.f)
      $display("FAIL %s_result: got r=%h f=%b want r=%h f=%b", name, bus.result_q, bus.flags_q, e.r, e.f);
    else passed++;
    total++;
    if (bus.shown_value !== e.r) $display("FAIL %s_shown: got %h want %h", name, bus.shown_value, e.r);
    else passed++;
    exit_show();
    total++;
    if (bus.state_o !== 2'b00 || bus.result_valid !== 1'b0 || bus.result_q !== e.r)
      $display("FAIL %s_exit: got st=%b v=%b r=%h want st=00 v=0 r=%h",
               name, bus.state_o, bus.result_valid, bus.result_q, e.r);
    else passed++;
  endtask

  task automatic test_add_overflow();
    test_single("add_overflow", 8'h7F, 8'h01, 2'b01, 8'h80, 5'b10011);
  endtask

  task automatic test_sub_zero();
    test_single("sub_zero", 8'h05, 8'h05, 2'b00, 8'h00, 5'b01000);
  endtask

  task automatic test_sub_borrow();
    test_single("sub_borrow", 8'h00, 8'h01, 2'b00, 8'hFF, 5'b10100);
  endtask

  task automatic test_live_op();
    bit                    ok;
    exp_t                  e;
    logic [1:0]            ops[2]   = '{2'b10, 2'b11};
    logic [M-1:0]          res[2]   = '{8'hFF, 8'h00};
    logic [4:0]            flg[2]   = '{5'b10000, 5'b01000};
    run_op(8'hF0, 8'h0F, 2'b01, 8'hFF, 5'b10000);
    wait_valid(ok);
    e = sb.pop_front();
    total++;
    if (!ok || bus.result_q !== e.r || bus.flags_q !== e.f)
      $display("FAIL live_initial: ok=%0d r=%h f=%b want r=%h f=%b", ok, bus.result_q, bus.flags_q, e.r, e.f);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.data_in = M'(ops[i]);
      e.r = res[i];
      e.f = flg[i];
      sb.push_back(e);
      @(posedge clk);
      #1;
      total++;
      if (bus.result_valid !== 1'b0) $display("FAIL live_stale_%0d: valid got %b want 0", i, bus.result_valid);
      else passed++;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (bus.result_valid !== 1'b1 || bus.result_q !== e.r || bus.flags_q !== e.f)
        $display("FAIL live_new_%0d: v=%b r=%h f=%b want v=1 r=%h f=%b",
                 i, bus.result_valid, bus.result_q, bus.flags_q, e.r, e.f);
      else passed++;
    end
    // Opcode change and enter press on the same edge: the exit wins.
    @(negedge clk);
    bus.data_in = M'(2'b01);
    bus.enter   = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.state_o !== 2'b00 || bus.result_valid !== 1'b0 || bus.op_q !== 2'b11)
      $display("FAIL live_exit_wins: st=%b v=%b op=%b want st=00 v=0 op=11",
               bus.state_o, bus.result_valid, bus.op_q);
    else passed++;
    total++;
    if (bus.shown_value !== bus.data_in) $display("FAIL live_shown_switches: got %h want %h", bus.shown_value, M'(2'b01));
    else passed++;
    @(negedge clk);
    bus.enter = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit           ok;
    exp_t         e, m;
    logic [M-1:0] a, b;
    logic [1:0]   op;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        a  = (i % 2 == 0) ? '1 : '0;
        b  = (i < 2) ? '1 : '0;
        op = 2'(i);
      end else begin
        a  = M'($urandom);
        b  = M'($urandom);
        op = 2'($urandom_range(0, 3));
      end
      m = model(a, b, op);
      run_op(a, b, op, m.r, m.f);
      wait_valid(ok);
      e = sb.pop_front();
      total++;
      if (!ok || bus.result_q !== e.r || bus.flags_q !== e.f)
        $display("FAIL b2b_%0d a=%h b=%h op=%b: ok=%0d r=%h f=%b want r=%h f=%b",
                 i, a, b, op, ok, bus.result_q, bus.flags_q, e.r, e.f);
      else passed++;
      exit_show();
    end
  endtask

  task automatic test_held_enter_reset();
    @(negedge clk);
    bus.data_in = 8'h33;
    bus.enter   = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (bus.state_o !== 2'b01 || bus.a_q !== 8'h33)
      $display("FAIL held_enter: st=%b a=%h want st=01 a=33", bus.state_o, bus.a_q);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.state_o, bus.a_q, bus.b_q, bus.op_q, bus.result_q, bus.flags_q, bus.result_valid} !== '0)
      $display("FAIL async_reset: st=%b a=%h b=%h op=%b r=%h f=%b v=%b want all zero",
               bus.state_o, bus.a_q, bus.b_q, bus.op_q, bus.result_q, bus.flags_q, bus.result_valid);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.state_o !== 2'b01 || bus.a_q !== 8'h33)
      $display("FAIL enter_across_reset: st=%b a=%h want st=01 a=33", bus.state_o, bus.a_q);
    else passed++;
    @(negedge clk);
    bus.enter = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_sub_borrow();
    test_live_op();
    test_back_to_back();
    test_held_enter_reset();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
